// File: rtl/unit_a_sequencer.sv
// Command-driven sequencer for the 32-bit arithmetic unit unit_a: registers operands,
// waits SETTLE cycles per iteration, optionally feeds S back into A, returns the result.

module unit_a (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  f,
  output logic [31:0] s,
  output logic        c_out
);
  // Subtraction is A + ~B + 1, so c_out reads as "no borrow".
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    {c_out, s} = {1'b0, a} + {1'b0, b};
    case (f)
      4'b0101: {c_out, s} = {1'b0, a} + {1'b0, ~b} + 33'd1;
      4'b0110: begin
        s     = ~a;
        c_out = 1'b0;
      end
      4'b0111: {c_out, s} = {1'b0, a} + 33'd1;
      default: ;
    endcase
  end
endmodule

module unit_a_sequencer #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_s,
  output logic             rsp_carry,
  output logic             rsp_carry_any,
  output logic             busy
);
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t             state, state_nxt;
  logic [31:0]        u_a, u_b, s;
  logic [3:0]         u_f;
  logic [CNT_W-1:0]   iter;
  logic [SET_W-1:0]   settle;
  logic               sticky, c_out;
  logic               settle_done, last_iter;

  unit_a u_unit_a (
    .a     (u_a),
    .b     (u_b),
    .f     (u_f),
    .s     (s),
    .c_out (c_out)
  );

  assign settle_done = (settle == '0);
  assign last_iter   = (iter == '0);
  assign cmd_ready   = (state == IDLE) && !rst;
  assign rsp_valid   = (state == DONE);
  assign busy        = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid)                  state_nxt = DRIVE;
      DRIVE:   if (settle_done && last_iter)   state_nxt = DONE;
      DONE:    if (rsp_ready)                  state_nxt = IDLE;
      default:                                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      u_a           <= '0;
      u_b           <= '0;
      u_f           <= 4'b0100;
      iter          <= '0;
      settle        <= '0;
      sticky        <= 1'b0;
      rsp_s         <= '0;
      rsp_carry     <= 1'b0;
      rsp_carry_any <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          u_a    <= cmd_a;
          u_b    <= cmd_b;
          u_f    <= {2'b01, cmd_op};
          iter   <= cmd_cnt;
          settle <= SET_W'(SETTLE - 1);
          sticky <= 1'b0;
        end
        DRIVE: begin
          if (!settle_done) begin
            settle <= settle - 1'b1;
          end else if (!last_iter) begin
            // Feed the settled result back as the next A operand.
            u_a    <= s;
            sticky <= sticky | c_out;
            iter   <= iter - 1'b1;
            settle <= SET_W'(SETTLE - 1);
          end else begin
            rsp_s         <= s;
            rsp_carry     <= c_out;
            rsp_carry_any <= sticky | c_out;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_unit_a_sequencer.sv
// Directed, table-driven bench for unit_a_sequencer with default parameters,
// plus hand-written backpressure and mid-operation reset sequences.

module tb_unit_a_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_cnt;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_s;
  logic        rsp_carry, rsp_carry_any, busy;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] OP_SUM = 2'b00, OP_SUB = 2'b01, OP_AINV = 2'b10, OP_INC = 2'b11;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  cnt;
    logic [31:0] s;
    logic        carry;
    logic        any;
    logic        chk_c;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  unit_a_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_cnt       (cmd_cnt),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_s         (rsp_s),
    .rsp_carry     (rsp_carry),
    .rsp_carry_any (rsp_carry_any),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Starts just after a negedge; returns at the negedge where rsp_valid is seen.
  // lat counts rising edges after the accept edge; -1 on timeout.
  task automatic wait_rsp(input string name, output int lat);
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rsp_valid) return;
      check({name, " busy"}, {31'd0, busy}, 32'd1);
      @(posedge clk);
      lat++;
    end
    lat = -1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] cnt);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_cnt   = cnt;
    cmd_valid = 1'b1;
    check("cmd_ready before accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic ack(input string name);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check({name, " rsp_valid after ack"}, {31'd0, rsp_valid}, 32'd0);
    check({name, " cmd_ready after ack"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    send(v.op, v.a, v.b, v.cnt);
    wait_rsp(v.name, lat);
    check({v.name, " latency"}, lat, v.lat);
    check({v.name, " rsp_s"}, rsp_s, v.s);
    if (v.chk_c) begin
      check({v.name, " rsp_carry"}, {31'd0, rsp_carry}, {31'd0, v.carry});
      check({v.name, " rsp_carry_any"}, {31'd0, rsp_carry_any}, {31'd0, v.any});
    end
    ack(v.name);
  endtask

  initial begin
    logic [31:0] held_s;
    int          lat;
    int          seen;

    vecs[0] = '{"sum 6+6",        OP_SUM,  32'd6,          32'd6,          4'd0,  32'h0000000C, 1'b0, 1'b0, 1'b1, 2};
    vecs[1] = '{"sum wrap",       OP_SUM,  32'hFFFFFFFF,   32'd1,          4'd0,  32'h00000000, 1'b1, 1'b1, 1'b1, 2};
    vecs[2] = '{"inc x5",         OP_INC,  32'd0,          32'd0,          4'd4,  32'd5,        1'b0, 1'b0, 1'b1, 10};
    vecs[3] = '{"sum 6+3*6",      OP_SUM,  32'd6,          32'd6,          4'd2,  32'd24,       1'b0, 1'b0, 1'b1, 6};
    vecs[4] = '{"ainv x1",        OP_AINV, 32'd0,          32'd0,          4'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 2};
    vecs[5] = '{"ainv x2",        OP_AINV, 32'd0,          32'd0,          4'd1,  32'd0,        1'b0, 1'b0, 1'b0, 4};
    vecs[6] = '{"sub 6-6",        OP_SUB,  32'd6,          32'd6,          4'd0,  32'd0,        1'b0, 1'b0, 1'b0, 2};
    vecs[7] = '{"inc mid carry",  OP_INC,  32'hFFFFFFFE,   32'd0,          4'd2,  32'd1,        1'b0, 1'b1, 1'b1, 6};
    vecs[8] = '{"sum early carry",OP_SUM,  32'h80000000,   32'h80000000,   4'd1,  32'h80000000, 1'b0, 1'b1, 1'b1, 4};
    vecs[9] = '{"inc cnt max",    OP_INC,  32'd0,          32'd0,          4'd15, 32'd16,       1'b0, 1'b0, 1'b1, 32};

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = OP_SUM; cmd_a = '0; cmd_b = '0; cmd_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset rsp_s", rsp_s, 32'd0);
    check("reset rsp_carry", {31'd0, rsp_carry}, 32'd0);
    check("reset rsp_carry_any", {31'd0, rsp_carry_any}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle cmd_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure: response must hold while new commands are offered.
    send(OP_SUM, 32'd1, 32'd2, 4'd0);
    wait_rsp("bp", lat);
    check("bp latency", lat, 2);
    held_s = 32'd3;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = i[0];
      cmd_a     = 32'(i * 100);
      cmd_op    = OP_INC;
      check("bp rsp_valid held", {31'd0, rsp_valid}, 32'd1);
      check("bp rsp_s held", rsp_s, held_s);
      check("bp cmd_ready low", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b1; cmd_op = OP_SUM; cmd_a = 32'd10; cmd_b = 32'd20; cmd_cnt = 4'd0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("bp rsp_valid after ack", {31'd0, rsp_valid}, 32'd0);
    check("bp pending cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_rsp("bp pending", lat);
    check("bp pending latency", lat, 2);
    check("bp pending rsp_s", rsp_s, 32'd30);
    ack("bp pending");

    // Reset in the middle of a long inc command discards it.
    send(OP_INC, 32'd100, 32'd0, 4'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("mid rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid rst busy", {31'd0, busy}, 32'd0);
    check("mid rst rsp_s", rsp_s, 32'd0);
    check("mid rst rsp_carry_any", {31'd0, rsp_carry_any}, 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    check("mid rst no response", seen, 0);
    run_vec('{"post rst sum", OP_SUM, 32'd6, 32'd6, 4'd0, 32'h0000000C, 1'b0, 1'b0, 1'b1, 2});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/unit_a_sequencer.md
# unit_a_sequencer

Command-driven sequencer for the 32-bit arithmetic unit `unit_A`. It accepts operations over a valid/ready command port and drives `unit_A`'s `A`, `B` and `f` inputs from registers. It waits a fixed settle time, captures `S`/`c_out`, and optionally iterates by feeding `S` back into `A`. The final result is presented on a valid/ready response port. It is the initiator side of the `unit_A` interface and is the path by which control logic issues arithmetic operations.

## Interface
Parameters:
- `SETTLE`, default 2: cycles `unit_A` inputs are held stable before `S`/`c_out` are sampled. Legal range is ≥1.
- `CNT_W`, default 4: width of the iteration-count field.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: block can accept a command.
- `cmd_op`  in  2: operation select.
  - 00 sum
  - 01 sub
  - 10 ainv
  - 11 inc
- `cmd_a`  in  32: operand A.
- `cmd_b`  in  32: operand B.
- `cmd_cnt`  in  `CNT_W`: extra iterations; total iterations = `cmd_cnt`+1.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer accepts result.
- `rsp_s`  out  32: final `S`.
- `rsp_carry`  out  1: `c_out` of the final iteration.
- `rsp_carry_any`  out  1: OR of `c_out` over all iterations.
- `busy`  out  1: high whenever not in IDLE.

## Operation
- `unit_A` is instantiated internally. Its `f` input = {2'b01, `cmd_op`}, i.e. 0100/0101/0110/0111.
- Internal registers:
  - `u_a`, `u_b`, `u_f` drive `unit_A`.
  - `iter` counts remaining iterations.
  - `settle` is the settle countdown.
  - `sticky` accumulates carry.
- States:
  - IDLE: `cmd_ready`=1. On `cmd_valid`, load `u_a`←`cmd_a`, `u_b`←`cmd_b`, `u_f`←{01,`cmd_op`}, `iter`←`cmd_cnt`, `settle`←`SETTLE`-1, `sticky`←0, then go to DRIVE.
  - DRIVE: `unit_A` inputs held constant. Decrement `settle` each cycle. When `settle`=0:
    - If `iter`≠0: `u_a`←`S`, `sticky`←`sticky`|`c_out`, `iter`←`iter`-1, `settle`←`SETTLE`-1; stay in DRIVE. `u_b` and `u_f` are unchanged.
    - If `iter`=0: `rsp_s`←`S`, `rsp_carry`←`c_out`, `rsp_carry_any`←`sticky`|`c_out`; go to DONE.
  - DONE: `rsp_valid`=1 and the response is held stable. On `rsp_ready`, go to IDLE.
- Commands are not accepted in DRIVE or DONE. `cmd_*` inputs are ignored outside IDLE.
- Iteration semantics, with operands held in B:
  - sum repeated: A + (n+1)·B mod 2^32.
  - inc repeated: A+n+1.
  - ainv repeated: bitwise NOT applied n+1 times.
  - sub repeated: A−(n+1)·B.

## Timing
- Reset values:
  - `cmd_ready`=0 during the reset cycle, then 1 (state IDLE).
  - `rsp_valid`=0, `rsp_s`=0, `rsp_carry`=0, `rsp_carry_any`=0, `busy`=0.
  - `u_a`=`u_b`=0, `u_f`=4'b0100, `iter`=0, `settle`=0, `sticky`=0.
- Accept happens at edge E0 where `cmd_valid`&`cmd_ready`. `unit_A` sees the new inputs in the cycle after E0.
- Latency: `rsp_valid` rises after edge E0 + (`cmd_cnt`+1)·`SETTLE`. With defaults and `cmd_cnt`=0, `rsp_valid` is high 2 cycles after accept.
- `rsp_valid`&`rsp_ready` at edge E1 → IDLE. `cmd_ready` is high in the cycle after E1. The minimum gap between accepts is (`cmd_cnt`+1)·`SETTLE`+2 cycles.
- `rsp_valid` stays high indefinitely while `rsp_ready`=0. Response fields do not change while `rsp_valid`=1.
- `cmd_cnt` at maximum (all ones) gives 2^`CNT_W` iterations. `iter` never wraps; it stops at 0.
- `rst` in any state: next cycle all outputs are at reset values and the in-flight command is discarded with no response. `rst` dominates a simultaneous accept or `rsp_ready`.
- `SETTLE`=1: each iteration occupies exactly one DRIVE cycle.

## Test plan
- Reset, then sum with A=6, B=6, cnt=0 → `rsp_valid` exactly 2 cycles after accept; `rsp_s`=0x0000000C; `rsp_carry`=0.
- Sum with A=0xFFFFFFFF, B=1, cnt=0 → `rsp_s`=0; `rsp_carry`=1; `rsp_carry_any`=1.
- Inc with A=0, cnt=4 → `rsp_s`=5 after 10 cycles; `busy` high throughout. Sum with A=6, B=6, cnt=2 → `rsp_s`=24.
- Ainv with A=0, cnt=0 → `rsp_s`=0xFFFFFFFF. Ainv with cnt=1 → `rsp_s`=0. Sub with A=6, B=6, cnt=0 → `rsp_s`=0.
- Hold `rsp_ready`=0 for 5 cycles while toggling `cmd_valid` → `rsp_*` stable; `cmd_ready`=0; no second command taken; the pending command is accepted only after the response handshake.
- Assert `rst` mid-DRIVE of an inc cnt=7 command → no response; all outputs at reset values the next cycle; a following sum 6+6 returns 12.
